// File: rtl/id_pkg.sv
// Shared definitions for the instruction decode stage: opcode/funct
// constants, ALU operation encoding, the ID/EX register layout and the
// control decoder used by instruction_decode.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // ID/EX register payload (PC is kept separately since its width is a parameter)
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    alu_op_t     alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } idex_t;

  // Decoded control for the instruction currently in ID
  typedef struct packed {
    logic    known;
    logic    reads_rs;
    logic    reads_rt;
    logic    is_branch;
    logic    branch_ne;
    logic    is_jump;
    logic    reg_write;
    logic    dest_is_rd;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_t alu_op;
  } ctrl_t;

  // Unsupported opcodes/functs (including the all-zero word) decode to all-zero control
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        c.known      = 1'b1;
        c.reads_rs   = 1'b1;
        c.reads_rt   = 1'b1;
        c.reg_write  = 1'b1;
        c.dest_is_rd = 1'b1;
        case (instr[5:0])
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c.known  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        c.known     = 1'b1;
        c.reads_rs  = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_LW: begin
        c.known     = 1'b1;
        c.reads_rs  = 1'b1;
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_SW: begin
        c.known     = 1'b1;
        c.reads_rs  = 1'b1;
        c.reads_rt  = 1'b1;
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.known     = 1'b1;
        c.reads_rs  = 1'b1;
        c.reads_rt  = 1'b1;
        c.is_branch = 1'b1;
        c.branch_ne = (instr[31:26] == OP_BNE);
        c.alu_op    = ALU_SUB;
      end
      OP_J: begin
        c.known   = 1'b1;
        c.is_jump = 1'b1;
        c.alu_op  = ALU_ADD;
      end
      default: c.known = 1'b0;
    endcase
    if (!c.known) c = '0;
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_reg_file.sv
// 32x32 register file, two asynchronous reads, one synchronous write.
// r0 always reads zero. With ID_RF_BYPASS_EN defined a read of the register
// being written this cycle returns the incoming write data.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  // Next register contents: single write port, r0 never written
  always_comb begin
    mem_d = mem_q;
    if (we && (wa != 5'd0)) mem_d[wa] = wd;
  end

  // Register storage, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : mem_q[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : mem_q[ra2];
`ifdef ID_RF_BYPASS_EN
    if (we && (wa != 5'd0) && (wa == ra1)) rd1 = wd;
    if (we && (wa != 5'd0) && (wa == ra2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/instruction_decode.sv
// Pipeline ID stage: register file, control decode, load-use / branch / write-back
// hazard stalls, branch and jump resolution, and the ID/EX pipeline register.
// Optional macro ID_RF_BYPASS_EN: register-file write-then-read bypass; when
// undefined, a source matching the in-flight write-back stalls one cycle instead.
module instruction_decode
  import id_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [INST_W-1:0] if_instruction,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_rd,
  output logic              ctr_nop,
  output logic              ctr_PC_src,
  output logic [PC_W-1:0]   PCin,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write
);

  ctrl_t           ctrl;
  logic [4:0]      f_rs, f_rt, f_rd;
  logic [31:0]     imm_sext;
  logic [31:0]     rs_data, rt_data;
  logic [PC_W-1:0] pc_plus4, br_target, j_target;
  logic            active, load_use, branch_haz, wb_haz, stall, redirect;

  idex_t           idex_q, idex_d;
  logic [PC_W-1:0] ex_pc_q, ex_pc_d;
  logic            squash_q, squash_d;

  reg_file u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (wb_reg_write & enable),
    .wa    (wb_rd),
    .wd    (wb_data),
    .ra1   (f_rs),
    .rd1   (rs_data),
    .ra2   (f_rt),
    .rd2   (rt_data)
  );

  // Field extraction, control decode and target computation
  always_comb begin
    ctrl      = decode_ctrl(if_instruction[31:0]);
    f_rs      = if_instruction[25:21];
    f_rt      = if_instruction[20:16];
    f_rd      = if_instruction[15:11];
    imm_sext  = {{16{if_instruction[15]}}, if_instruction[15:0]};
    pc_plus4  = if_pc + PC_W'(4);
    br_target = pc_plus4 + PC_W'({imm_sext[29:0], 2'b00});
    j_target  = {pc_plus4[PC_W-1:28], if_instruction[25:0], 2'b00};
  end

  // Hazard detection and redirect; a squashed or unknown instruction never stalls or redirects
  always_comb begin
    active   = enable & ~reset & ~squash_q & ctrl.known;
    load_use = idex_q.valid & idex_q.mem_read & (idex_q.dest != 5'd0) &
               ((ctrl.reads_rs & (idex_q.dest == f_rs)) |
                (ctrl.reads_rt & (idex_q.dest == f_rt)));
    branch_haz = ctrl.is_branch &
                 (((f_rs != 5'd0) & ((idex_q.reg_write & (idex_q.dest == f_rs)) |
                                     (mem_reg_write & (mem_rd == f_rs)))) |
                  ((f_rt != 5'd0) & ((idex_q.reg_write & (idex_q.dest == f_rt)) |
                                     (mem_reg_write & (mem_rd == f_rt)))));
`ifdef ID_RF_BYPASS_EN
    wb_haz = 1'b0;
`else
    wb_haz = wb_reg_write & (wb_rd != 5'd0) &
             ((ctrl.reads_rs & (wb_rd == f_rs)) | (ctrl.reads_rt & (wb_rd == f_rt)));
`endif
    stall    = active & (load_use | branch_haz | wb_haz);
    redirect = active & ~stall &
               (ctrl.is_jump |
                (ctrl.is_branch & ((rs_data == rt_data) ^ ctrl.branch_ne)));
    ctr_nop    = stall;
    ctr_PC_src = redirect;
    PCin       = ctrl.is_jump ? j_target : br_target;
  end

  // Next ID/EX contents: bubble on stall, squash or unknown instruction
  always_comb begin
    idex_d   = idex_q;
    ex_pc_d  = ex_pc_q;
    squash_d = squash_q;
    if (enable) begin
      squash_d = redirect;
      if (active && !stall) begin
        idex_d.valid     = 1'b1;
        idex_d.rs_data   = rs_data;
        idex_d.rt_data   = rt_data;
        idex_d.imm       = imm_sext;
        idex_d.rs        = f_rs;
        idex_d.rt        = f_rt;
        idex_d.dest      = !ctrl.reg_write ? 5'd0 : (ctrl.dest_is_rd ? f_rd : f_rt);
        idex_d.alu_op    = ctrl.alu_op;
        idex_d.alu_src   = ctrl.alu_src;
        idex_d.mem_read  = ctrl.mem_read;
        idex_d.mem_write = ctrl.mem_write;
        idex_d.reg_write = ctrl.reg_write;
        ex_pc_d          = if_pc;
      end else begin
        idex_d  = '0;
        ex_pc_d = '0;
      end
    end
  end

  // ID/EX register and squash flag
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q   <= '0;
      ex_pc_q  <= '0;
      squash_q <= 1'b0;
    end else begin
      idex_q   <= idex_d;
      ex_pc_q  <= ex_pc_d;
      squash_q <= squash_d;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = ex_pc_q;
  assign ex_rs_data   = idex_q.rs_data;
  assign ex_rt_data   = idex_q.rt_data;
  assign ex_imm       = idex_q.imm;
  assign ex_rs        = idex_q.rs;
  assign ex_rt        = idex_q.rt;
  assign ex_dest      = idex_q.dest;
  assign ex_alu_op    = idex_q.alu_op;
  assign ex_alu_src   = idex_q.alu_src;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_reg_write = idex_q.reg_write;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] if_instruction, if_pc;
  logic        wb_reg_write, mem_reg_write;
  logic [4:0]  wb_rd, mem_rd;
  logic [31:0] wb_data;
  logic        ctr_nop, ctr_PC_src;
  logic [31:0] PCin;
  logic        ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [2:0]  ex_alu_op;

  always #5 clk = ~clk;

  instruction_decode #(.PC_W(32), .INST_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .if_instruction(if_instruction), .if_pc(if_pc),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .ctr_nop(ctr_nop), .ctr_PC_src(ctr_PC_src), .PCin(PCin),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
  );

  int checks = 0;
  int errors = 0;

`ifdef ID_RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int K_BAD = 0, K_R = 1, K_ADDI = 2, K_LW = 3, K_SW = 4,
                 K_BEQ = 5, K_BNE = 6, K_J = 7;

  typedef struct {
    int          kind;
    bit          valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, dest;
    int          alu;
    bit          alu_src, mrd, mwr, rw;
  } exp_t;

  logic [31:0] m_regs [32];
  exp_t        m_ex;
  bit          m_squash;
  logic        last_nop, last_src;
  logic [31:0] last_pcin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic int kind_of(input logic [31:0] ins);
    if (ins == 32'd0) return K_BAD;
    case (ins[31:26])
      6'h00:   return (ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? K_R : K_BAD;
      6'h08:   return K_ADDI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h02:   return K_J;
      default: return K_BAD;
    endcase
  endfunction

  function automatic int alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'h20:   return 0;
      6'h22:   return 1;
      6'h24:   return 2;
      6'h25:   return 3;
      default: return 4;
    endcase
  endfunction

  // Value an instruction in ID sees for register r this cycle
  function automatic logic [31:0] read_reg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (BYPASS && enable && wb_reg_write && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  // One clock: check combinational controls, advance the model, check ID/EX
  task automatic step();
    int          k;
    logic [4:0]  rs, rt;
    logic [31:0] a, b, pc4, tgt, ins;
    bit          rrs, rrt, live, lu, bh, wh, nop, take;
    exp_t        nx;
    #2;
    ins  = if_instruction;
    k    = kind_of(ins);
    rs   = ins[25:21];
    rt   = ins[20:16];
    a    = read_reg(rs);
    b    = read_reg(rt);
    rrs  = k inside {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE};
    rrt  = k inside {K_R, K_SW, K_BEQ, K_BNE};
    live = enable && !reset && !m_squash && k != K_BAD;
    lu   = m_ex.valid && m_ex.mrd && m_ex.dest != 0 &&
           ((rrs && m_ex.dest == rs) || (rrt && m_ex.dest == rt));
    bh   = (k == K_BEQ || k == K_BNE) &&
           ((rs != 0 && ((m_ex.rw && m_ex.dest == rs) || (mem_reg_write && mem_rd == rs))) ||
            (rt != 0 && ((m_ex.rw && m_ex.dest == rt) || (mem_reg_write && mem_rd == rt))));
    wh   = !BYPASS && wb_reg_write && wb_rd != 0 &&
           ((rrs && wb_rd == rs) || (rrt && wb_rd == rt));
    nop  = live && (lu || bh || wh);
    take = live && !nop && (k == K_J || (k == K_BEQ && a == b) || (k == K_BNE && a != b));
    pc4  = if_pc + 32'd4;
    tgt  = (k == K_J) ? {pc4[31:28], ins[25:0], 2'b00}
                      : pc4 + {{16{ins[15]}}, ins[15:0]} * 32'd4;
    last_nop  = ctr_nop;
    last_src  = ctr_PC_src;
    last_pcin = PCin;
    chk("ctr_nop", {31'd0, ctr_nop}, {31'd0, nop});
    chk("ctr_PC_src", {31'd0, ctr_PC_src}, {31'd0, take});
    if (take) chk("PCin", PCin, tgt);

    nx = m_ex;
    if (reset) nx = '{default: 0};
    else if (enable) begin
      nx = '{default: 0};
      if (live && !nop) begin
        nx.kind    = k;
        nx.valid   = 1;
        nx.pc      = if_pc;
        nx.rs_data = a;
        nx.rt_data = b;
        nx.imm     = {{16{ins[15]}}, ins[15:0]};
        nx.rs      = rs;
        nx.rt      = rt;
        nx.alu     = (k == K_R) ? alu_of_funct(ins[5:0]) : 0;
        nx.alu_src = k inside {K_ADDI, K_LW, K_SW};
        nx.mrd     = (k == K_LW);
        nx.mwr     = (k == K_SW);
        nx.rw      = k inside {K_R, K_ADDI, K_LW};
        nx.dest    = (k == K_R) ? ins[15:11] : (k inside {K_ADDI, K_LW}) ? rt : 5'd0;
      end
    end

    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_squash = 0;
    end else if (enable) begin
      if (wb_reg_write && wb_rd != 0) m_regs[wb_rd] = wb_data;
      m_squash = take;
    end
    m_ex = nx;
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex.valid});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_ex.mrd});
    chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m_ex.mwr});
    chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_ex.rw});
    if (m_ex.valid) begin
      chk("ex_pc", ex_pc, m_ex.pc);
      chk("ex_rs", {27'd0, ex_rs}, {27'd0, m_ex.rs});
      chk("ex_rt", {27'd0, ex_rt}, {27'd0, m_ex.rt});
      chk("ex_imm", ex_imm, m_ex.imm);
      chk("ex_rs_data", ex_rs_data, m_ex.rs_data);
      chk("ex_rt_data", ex_rt_data, m_ex.rt_data);
      if (m_ex.kind inside {K_R, K_ADDI, K_LW, K_SW}) begin
        chk("ex_dest", {27'd0, ex_dest}, {27'd0, m_ex.dest});
        chk("ex_alu_op", {29'd0, ex_alu_op}, 32'(m_ex.alu));
        chk("ex_alu_src", {31'd0, ex_alu_src}, {31'd0, m_ex.alu_src});
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    int rs = $urandom_range(0, 7);
    int rt = $urandom_range(0, 7);
    int rd = $urandom_range(0, 7);
    logic [15:0] imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0:       return enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
      1:       return enc_r(rs, rt, rd, 6'($urandom));
      2:       return enc_i(6'h08, rs, rt, imm);
      3:       return enc_i(6'h23, rs, rt, imm);
      4:       return enc_i(6'h2B, rs, rt, imm);
      5:       return enc_i(6'h04, rs, rt, imm);
      6:       return enc_i(6'h05, rs, rt, imm);
      7:       return {6'h02, 26'($urandom)};
      8:       return $urandom;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    m_ex = '{default: 0};
    m_squash = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    reset = 1; enable = 1; if_instruction = 32'd0; if_pc = 32'd0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0; mem_reg_write = 0; mem_rd = 0;

    // Reset
    step(); step();
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    chk("rst_ex_dest", {27'd0, ex_dest}, 32'd0);
    reset = 0;

    // addi r1,r0,5 with write-back of r1, then addi r2,r1,3
    if_pc = 32'h100; if_instruction = enc_i(6'h08, 0, 1, 16'd5);
    wb_reg_write = 1; wb_rd = 1; wb_data = 32'd5;
    step();
    chk("addi1_imm", ex_imm, 32'd5);
    chk("addi1_dest", {27'd0, ex_dest}, 32'd1);
    chk("addi1_alu_op", {29'd0, ex_alu_op}, 32'd0);
    chk("addi1_alu_src", {31'd0, ex_alu_src}, 32'd1);
    wb_reg_write = 0;
    if_pc = 32'h104; if_instruction = enc_i(6'h08, 1, 2, 16'd3);
    step();
    chk("addi2_imm", ex_imm, 32'd3);
    chk("addi2_dest", {27'd0, ex_dest}, 32'd2);
    chk("addi2_rs_data", ex_rs_data, 32'd5);

    // Load-use: lw r3,0(r0); add r4,r3,r3
    if_pc = 32'h108; if_instruction = enc_i(6'h23, 0, 3, 16'd0);
    step();
    if_pc = 32'h10C; if_instruction = enc_r(3, 3, 4, 6'h20);
    step();
    chk("lu_nop", {31'd0, last_nop}, 32'd1);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    step();
    chk("lu_release", {31'd0, last_nop}, 32'd0);
    chk("lu_add_rs", {27'd0, ex_rs}, 32'd3);

    // r1 = r2 = 7, then beq r1,r2,+4 at 0x40, next instruction squashed
    if_instruction = 32'd0;
    wb_reg_write = 1; wb_rd = 1; wb_data = 32'd7; step();
    wb_rd = 2; step();
    wb_reg_write = 0;
    if_pc = 32'h40; if_instruction = enc_i(6'h04, 1, 2, 16'd4);
    step();
    chk("beq_src", {31'd0, last_src}, 32'd1);
    chk("beq_target", last_pcin, 32'h54);
    chk("beq_valid", {31'd0, ex_valid}, 32'd1);
    if_pc = 32'h44; if_instruction = enc_i(6'h08, 0, 9, 16'd1);
    step();
    chk("squash_valid", {31'd0, ex_valid}, 32'd0);
    chk("squash_src", {31'd0, last_src}, 32'd0);

    // j 0x100 at 0x10000040
    if_pc = 32'h1000_0040; if_instruction = {6'h02, 26'h100};
    step();
    chk("j_src", {31'd0, last_src}, 32'd1);
    chk("j_target", last_pcin, 32'h1000_0400);
    if_instruction = 32'd0; step();

    // Write r5=0xAB in the same cycle add r6,r5,r0 decodes
    if_pc = 32'h200; if_instruction = enc_r(5, 0, 6, 6'h20);
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'hAB;
    step();
    wb_reg_write = 0;
`ifdef ID_RF_BYPASS_EN
    chk("byp_nop", {31'd0, last_nop}, 32'd0);
    chk("byp_rs_data", ex_rs_data, 32'hAB);
`else
    chk("wb_nop", {31'd0, last_nop}, 32'd1);
    chk("wb_bubble", {31'd0, ex_valid}, 32'd0);
    step();
    chk("wb_rs_data", ex_rs_data, 32'hAB);
`endif

    // enable low for 3 cycles while a load-use stall is pending
    if_pc = 32'h300; if_instruction = enc_i(6'h23, 0, 7, 16'd0);
    step();
    if_pc = 32'h304; if_instruction = enc_r(7, 0, 8, 6'h20);
    enable = 0;
    repeat (3) begin
      step();
      chk("frz_nop", {31'd0, last_nop}, 32'd0);
      chk("frz_mem_read", {31'd0, ex_mem_read}, 32'd1);
      chk("frz_dest", {27'd0, ex_dest}, 32'd7);
    end
    enable = 1;
    step();
    chk("frz_stall", {31'd0, last_nop}, 32'd1);
    step();
    chk("frz_resume_dest", {27'd0, ex_dest}, 32'd8);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset         = ($urandom_range(0, 99) < 2);
      enable        = ($urandom_range(0, 9) != 0);
      wb_reg_write  = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 7));
      wb_data       = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 7));
      if_pc         = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                                  : ($urandom & 32'hFFFF_FFFC);
      if_instruction = rand_instr();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
